// File: rtl/sift_row_mem_arbiter.sv
// Round-robin, burst-locked arbiter for the shared 480x5120 row SRAM.
// Per-requester read tagging and address checking live in sift_row_req_lane.

module sift_row_req_lane #(
  parameter int ADDR_W    = 9,
  parameter int ROW_DEPTH = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gnt,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  output logic              legal,
  output logic              rvalid,
  output logic              addr_err
);
  logic accept;

  assign legal  = int'(addr) < ROW_DEPTH;
  assign accept = gnt & req;

  // One-deep tag: the SRAM returns read data exactly one cycle after the access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rvalid   <= accept & legal & ~we;
      addr_err <= accept & ~legal;
    end
  end
endmodule

module sift_row_mem_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 9,
  parameter int ROW_DEPTH = 480,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [1:0]                owner,
  output logic                      busy,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [NUM_REQ-1:0]        addr_err
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, OWN} state_t;

  state_t                          state, state_nxt;
  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_v;
  logic [NUM_REQ-1:0]              legal;
  logic [NUM_REQ-1:0]              gnt_nxt, cand;
  logic [1:0]                      ptr, ptr_nxt, owner_nxt, win;
  logic                            win_vld, accept, beat_ok;
  logic [CNT_W-1:0]                cnt, cnt_nxt;

  assign addr_v = req_addr;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    sift_row_req_lane #(.ADDR_W(ADDR_W), .ROW_DEPTH(ROW_DEPTH)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .gnt      (gnt[i]),
      .req      (req[i]),
      .we       (req_we[i]),
      .addr     (addr_v[i]),
      .legal    (legal[i]),
      .rvalid   (rvalid[i]),
      .addr_err (addr_err[i])
    );
  end

  assign busy     = |gnt;
  assign accept   = (state == OWN) & req[owner];
  assign beat_ok  = accept & legal[owner];
  assign mem_en   = beat_ok;
  assign mem_we   = beat_ok & req_we[owner];
  assign mem_addr = beat_ok ? addr_v[owner] : '0;

  // Candidates exclude the owner; when the owner drops req this is all requesters anyway.
  assign cand = (state == ARB) ? req : (req & ~gnt);

  always_comb begin
    int idx;
    idx     = 0;
    win     = ptr;
    win_vld = 1'b0;
    // Walk from farthest to nearest so the closest to ptr+1 wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (cand[idx]) begin
        win     = 2'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      ARB: begin
        if (win_vld) begin
          state_nxt = OWN;
          gnt_nxt   = NUM_REQ'(1) << win;
          owner_nxt = win;
          ptr_nxt   = win;
          cnt_nxt   = '0;
        end
      end
      OWN: begin
        if (!accept) begin
          if (win_vld) begin
            gnt_nxt   = NUM_REQ'(1) << win;
            owner_nxt = win;
            ptr_nxt   = win;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ARB;
            gnt_nxt   = '0;
          end
        end else if (cnt == CNT_W'(MAX_BURST - 1)) begin
          cnt_nxt = '0;
          if (win_vld) begin
            gnt_nxt   = NUM_REQ'(1) << win;
            owner_nxt = win;
            ptr_nxt   = win;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ARB;
      gnt   <= '0;
      owner <= '0;
      ptr   <= 2'(NUM_REQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end
endmodule

// File: doc/sift_row_mem_arbiter.md
Name: sift_row_mem_arbiter

Overview:
- Round-robin arbiter with burst locking for one single-port row SRAM (480 rows x 5120 bits).
- Shares the memory between NUM_REQ requesters: image loader, Gaussian blur engines and the keypoint detect/filter engine.
- Forwards the granted requester's address and write strobe, tags each read so the 1-cycle-latency read valid returns to its issuer, and rejects out-of-range addresses.
- The 5120-bit data buses bypass this block: write data is muxed by the owner id, read data fans out directly.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = loader, 1 = gaussian, 2 = detect_filter.
- ADDR_W, 9, row address width.
- ROW_DEPTH, 480, number of valid rows; addresses >= ROW_DEPTH are illegal.
- MAX_BURST, 16, accepted beats before the owner must yield if another requester is waiting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req  in  NUM_REQ  per-requester access request, held until accepted
- req_we  in  NUM_REQ  per-requester write strobe, qualified by req
- req_addr  in  NUM_REQ*ADDR_W  packed row addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  registered one-hot grant
- owner  out  2  index of the granted requester; valid while busy
- busy  out  1  some requester holds the grant
- mem_en  out  1  SRAM access enable (combinational)
- mem_we  out  1  SRAM write enable (combinational)
- mem_addr  out  ADDR_W  SRAM row address (combinational)
- rvalid  out  NUM_REQ  one-hot; read data on the SRAM dout is valid for that requester
- addr_err  out  NUM_REQ  one-cycle pulse; that requester's access was rejected

Behaviour:
- Reset (rst_n=0 at a clk edge): gnt=0, owner=0, busy=0, rvalid=0, addr_err=0, round-robin pointer=NUM_REQ-1, burst count=0, FSM=ARB.
  - mem_en, mem_we and mem_addr read 0 while no grant is held.
  - Reset mid-burst drops the grant immediately and discards any pending rvalid.
- Beat acceptance: a beat is accepted in cycle t when gnt[i] & req[i].
  - Legal address (req_addr[i] < ROW_DEPTH): mem_en=1 and mem_addr=req_addr[i] in the same cycle; mem_we=req_we[i].
  - Accepted read: rvalid[i]=1 in cycle t+1 only, aligned with the SRAM dout.
  - Accepted write: no rvalid.
  - Illegal address: mem_en=0, mem_we=0, addr_err[i]=1 in cycle t+1. The beat still counts as accepted; the requester must advance.
  - Every cycle without an accepted legal beat: mem_en=0, mem_we=0, mem_addr=0.
- FSM state ARB (no owner):
  - If any req is high, the winner is the first requester with req high, searching from pointer+1 with wrap-around.
  - Next cycle: gnt=onehot(winner), owner=winner, busy=1, pointer=winner, count=0, FSM=OWN.
  - The request cycle itself is never a granted cycle, so first-access latency is 1 cycle from req to gnt.
- FSM state OWN:
  - Each accepted beat increments count.
  - Owner drops req: the grant is released and the next owner is arbitrated in that same cycle. If another req is high, gnt switches directly next cycle with no idle cycle. Otherwise FSM goes to ARB with gnt=0.
  - Accepted beat that makes count==MAX_BURST while another req is high: rearbitrate from pointer+1, and gnt switches next cycle.
  - count==MAX_BURST with no other requester waiting: count resets to 0 and the owner keeps the grant.
- Simultaneous events:
  - Owner drop and a new req in the same cycle: the new requester is granted next cycle.
  - All requesters high from ARB with pointer=2: grant order is 0, 1, 2, 0, ...
- The pending rvalid tag is one entry deep; the 1-cycle SRAM latency never needs more.
- Invariant: gnt is zero or one-hot at all times; busy == |gnt.

Test Plan:
- Reset, then req=3'b010 with addr 9'd5, read -> gnt=3'b010 next cycle; mem_en=1 and mem_addr=5 that cycle; rvalid=3'b010 exactly one cycle later; owner=1.
- req=3'b111 held for 40 beats, MAX_BURST=16 -> grant sequence 0 (16 beats), 1 (16 beats), 2; no cycle with gnt=0 between owners; gnt always one-hot.
- Requester 1 alone for 20 beats -> keeps the grant through count wrap, 20 consecutive mem_en cycles.
- Requester 2 write at addr 9'd480 -> mem_en=0 and mem_we=0 that cycle; addr_err=3'b100 for one cycle next cycle; no rvalid.
- Requester 0 drops req in the same cycle requester 2 raises req -> gnt=3'b100 next cycle, no idle gap.
- rst_n low mid-burst right after an accepted read -> next cycle gnt=0, busy=0, rvalid=0.
